// File: rtl/seg7_pkg.sv
// Purpose: shared constants for the multiplexed 3-digit 7-segment display driver.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
//
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NUM_DIGITS = 3;

    typedef logic [6:0] seg_t;
    typedef logic [3:0] an_t;

    localparam seg_t SEG_0     = 7'b1000000;
    localparam seg_t SEG_1     = 7'b1111001;
    localparam seg_t SEG_2     = 7'b0100100;
    localparam seg_t SEG_3     = 7'b0110000;
    localparam seg_t SEG_4     = 7'b0011001;
    localparam seg_t SEG_5     = 7'b0010010;
    localparam seg_t SEG_6     = 7'b0000010;
    localparam seg_t SEG_7     = 7'b1111000;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0010000;
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam an_t  AN_OFF    = 4'b1111;

    // Active-low one-hot anode for a digit slot; an[3] is never driven low.
    function automatic an_t an_select(input logic [1:0] idx);
        an_t r;
        r = AN_OFF;
        r[idx] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Purpose: BCD code to active-low 7-segment pattern; codes 10..15 show a dash.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_code : 4-bit digit code
//   o_seg  : active-low pattern {g,f,e,d,c,b,a}
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_7seg_scan.sv
// Purpose: captures a 3-digit BCD value on done and time-multiplexes it onto a 7-seg display.
// Latency: outputs change one cycle after the digit index advances; each slot lasts CLK_DIV cycles.
// Backpressure: none; done is sampled every cycle and the last capture wins.
//
// Ports:
//   clk  : system clock (rising edge)
//   rst  : synchronous active-high reset
//   done : single-cycle strobe, BCD valid
//   BCD  : BCD[0] units, BCD[1] tens, BCD[2] hundreds
//   seg  : active-low cathodes {g,f,e,d,c,b,a}, registered
//   an   : active-low digit anodes, registered; an[3] always high
module bcd_7seg_scan
    import seg7_pkg::*;
#(
    parameter int CLK_DIV = 50000,
    parameter bit LZB     = 1'b1
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       done,
    input  logic [3:0] BCD [NUM_DIGITS],
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int DIV_W = $clog2(CLK_DIV);

    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_idx;
    logic             r_load;
    logic             r_valid;
    logic [3:0]       r_dig [NUM_DIGITS];

    logic             w_tick;
    logic [3:0]       w_code;
    logic [6:0]       w_dec;
    logic             w_blank;

    assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));

    // Digit selected for the slot being loaded; index 3 is unreachable.
    always_comb begin
        w_code = r_dig[2];
        case (r_idx)
            2'd0:    w_code = r_dig[0];
            2'd1:    w_code = r_dig[1];
            default: w_code = r_dig[2];
        endcase
    end

    // Leading-zero blanking: hundreds dark when zero, tens dark only when
    // hundreds is also zero; units always lit once a value is captured.
    always_comb begin
        w_blank = ~r_valid;
        if (LZB) begin
            if (r_idx == 2'd2 && r_dig[2] == 4'd0)
                w_blank = 1'b1;
            if (r_idx == 2'd1 && r_dig[2] == 4'd0 && r_dig[1] == 4'd0)
                w_blank = 1'b1;
        end
    end

    seg7_decoder u_dec (
        .i_code (w_code),
        .o_seg  (w_dec)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= '0;
            r_idx   <= 2'd0;
            r_load  <= 1'b0;
            r_valid <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++)
                r_dig[k] <= 4'd0;
            an      <= AN_OFF;
            seg     <= SEG_BLANK;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);

            if (w_tick)
                r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;

            // One-cycle strobe following each index change; the outputs are
            // only reloaded here so a mid-slot capture cannot disturb the
            // digit already on display.
            r_load <= w_tick;

            if (r_load) begin
                an  <= w_blank ? AN_OFF    : an_select(r_idx);
                seg <= w_blank ? SEG_BLANK : w_dec;
            end

            if (done) begin
                r_valid <= 1'b1;
                for (int k = 0; k < NUM_DIGITS; k++)
                    r_dig[k] <= BCD[k];
            end
        end
    end

endmodule

// File: tb/tb_bcd_7seg_scan.sv
module tb_bcd_7seg_scan;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic [3:0] BCD [3];
    logic [6:0] seg0, seg1;
    logic [3:0] an0, an1;

    always #5 clk = ~clk;

    // Instance 0: blanking disabled; instance 1: blanking enabled.
    bcd_7seg_scan #(.CLK_DIV(D), .LZB(1'b0)) u_dut_nolzb (
        .clk (clk), .rst (rst), .done (done), .BCD (BCD), .seg (seg0), .an (an0)
    );
    bcd_7seg_scan #(.CLK_DIV(D), .LZB(1'b1)) u_dut_lzb (
        .clk (clk), .rst (rst), .done (done), .BCD (BCD), .seg (seg1), .an (an1)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b, expected %b", nm, $time, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // n counts clock edges since the last reset edge. A slot's content is
    // fixed at the edge where it becomes visible: edges D+1, 2D+1, ...,
    // showing digit ((n-1)/D) mod 3 with the value captured before that edge.
    function automatic logic [6:0] pattern(input logic [3:0] c);
        case (c)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    int         n;
    int         mk;
    bit         started = 1'b0;
    bit         m_valid;
    bit         m_blank;
    logic [3:0] m_cap [3];
    logic [3:0] m_an  [2];
    logic [6:0] m_seg [2];

    always @(posedge clk) begin
        if (rst) begin
            n       = 0;
            m_valid = 1'b0;
            for (int i = 0; i < 3; i++) m_cap[i] = 4'd0;
            for (int z = 0; z < 2; z++) begin
                m_an[z]  = 4'b1111;
                m_seg[z] = 7'b1111111;
            end
            started = 1'b1;
        end else if (started) begin
            n++;
            if (n > D && ((n - 1) % D) == 0) begin
                mk = ((n - 1) / D) % 3;
                for (int z = 0; z < 2; z++) begin
                    m_blank = !m_valid;
                    if (z == 1 && mk == 2 && m_cap[2] == 4'd0) m_blank = 1'b1;
                    if (z == 1 && mk == 1 && m_cap[2] == 4'd0 && m_cap[1] == 4'd0) m_blank = 1'b1;
                    m_an[z]  = m_blank ? 4'b1111 : (4'b1111 ^ (4'b0001 << mk));
                    m_seg[z] = m_blank ? 7'b1111111 : pattern(m_cap[mk]);
                end
            end
            if (done) begin
                m_valid = 1'b1;
                for (int i = 0; i < 3; i++) m_cap[i] = BCD[i];
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("an_nolzb",  {4'b0, an0},  {4'b0, m_an[0]});
            chk("seg_nolzb", {1'b0, seg0}, {1'b0, m_seg[0]});
            chk("an_lzb",    {4'b0, an1},  {4'b0, m_an[1]});
            chk("seg_lzb",   {1'b0, seg1}, {1'b0, m_seg[1]});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_bcd(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
        BCD[2] = h;
        BCD[1] = t;
        BCD[0] = u;
    endtask

    task automatic pulse_done();
        done = 1'b1;
        cycle();
        done = 1'b0;
    endtask

    // Ends at a negedge where an0 equals target (or after the budget expires).
    task automatic wait_an0(input logic [3:0] target, input string nm);
        bit found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (an0 === target) found = 1'b1;
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL %s timeout: an never reached %b, last %b", nm, target, an0);
        end
    endtask

    initial begin
        int cnt;
        int len;
        rst  = 1'b1;
        done = 1'b0;
        set_bcd(4'd0, 4'd0, 4'd0);

        // Reset and idle blank period
        cycle();
        cycle();
        @(negedge clk);
        chk("rst_an",  {4'b0, an0},  8'h0F);
        chk("rst_seg", {1'b0, seg0}, 8'h7F);
        chk("rst_an_lzb", {4'b0, an1}, 8'h0F);
        @(posedge clk); #2;
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (an0 !== 4'b1111 || seg0 !== 7'b1111111 || an1 !== 4'b1111) cnt++;
        end
        chki("idle_blank_cycles", cnt, 0);

        // 255
        @(posedge clk); #2;
        set_bcd(4'd2, 4'd5, 4'd5);
        pulse_done();
        wait_an0(4'b1110, "cap_d0");
        chk("cap_d0_seg", {1'b0, seg0}, {1'b0, 7'b0010010});
        wait_an0(4'b1101, "cap_d1");
        chk("cap_d1_seg", {1'b0, seg0}, {1'b0, 7'b0010010});
        len = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (an0 !== 4'b1101) break;
            len++;
        end
        chki("slot_len", len, 4);
        chk("cap_d2_an",  {4'b0, an0},  8'b0000_1011);
        chk("cap_d2_seg", {1'b0, seg0}, {1'b0, 7'b0100100});

        // 007: blanking on instance 1 only
        @(posedge clk); #2;
        set_bcd(4'd0, 4'd0, 4'd7);
        pulse_done();
        repeat (14) cycle();
        wait_an0(4'b1110, "lzb_d0");
        chk("lzb_d0_seg",  {1'b0, seg0}, {1'b0, 7'b1111000});
        chk("lzb_d0_an1",  {4'b0, an1},  8'b0000_1110);
        chk("lzb_d0_seg1", {1'b0, seg1}, {1'b0, 7'b1111000});
        wait_an0(4'b1101, "lzb_d1");
        chk("nolzb_d1_seg", {1'b0, seg0}, {1'b0, 7'b1000000});
        chk("lzb_d1_an1",   {4'b0, an1},  8'h0F);
        chk("lzb_d1_seg1",  {1'b0, seg1}, 8'h7F);
        wait_an0(4'b1011, "lzb_d2");
        chk("nolzb_d2_seg", {1'b0, seg0}, {1'b0, 7'b1000000});
        chk("lzb_d2_an1",   {4'b0, an1},  8'h0F);

        // Capture hold, then a mid-slot done
        @(posedge clk); #2;
        set_bcd(4'd1, 4'd2, 4'd3);
        repeat (14) cycle();
        wait_an0(4'b1110, "hold_d0");
        chk("hold_d0_seg", {1'b0, seg0}, {1'b0, 7'b1111000});
        wait_an0(4'b1011, "hold_sync");
        wait_an0(4'b1110, "mid_d0");
        @(posedge clk); #2;
        pulse_done();
        @(negedge clk);
        chk("mid_keep_an",  {4'b0, an0},  8'b0000_1110);
        chk("mid_keep_seg", {1'b0, seg0}, {1'b0, 7'b1111000});
        wait_an0(4'b1101, "mid_d1");
        chk("mid_d1_seg",  {1'b0, seg0}, {1'b0, 7'b0100100});
        chk("mid_d1_seg1", {1'b0, seg1}, {1'b0, 7'b0100100});
        wait_an0(4'b1011, "mid_d2");
        chk("mid_d2_seg",  {1'b0, seg0}, {1'b0, 7'b1111001});
        wait_an0(4'b1110, "mid_d0b");
        chk("mid_d0b_seg", {1'b0, seg0}, {1'b0, 7'b0110000});

        // Invalid digit in the tens position
        @(posedge clk); #2;
        set_bcd(4'd1, 4'hC, 4'd4);
        pulse_done();
        repeat (14) cycle();
        wait_an0(4'b1101, "dash_d1");
        chk("dash_seg",  {1'b0, seg0}, {1'b0, 7'b0111111});
        chk("dash_seg1", {1'b0, seg1}, {1'b0, 7'b0111111});

        // Reset in slot 1
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_an",  {4'b0, an0},  8'h0F);
        chk("mrst_seg", {1'b0, seg0}, 8'h7F);
        rst  = 1'b0;
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        cnt = 0;
        while (an0 === 4'b1111 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("mrst_first_an",  {4'b0, an0},  8'b0000_1101);
        chk("mrst_first_seg", {1'b0, seg0}, {1'b0, 7'b0111111});

        // Reset together with done
        @(negedge clk);
        rst  = 1'b1;
        done = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an0 !== 4'b1111 || an1 !== 4'b1111 || seg0 !== 7'b1111111) cnt++;
        end
        chki("rst_done_blank_cycles", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd_7seg_scan.md
BCD_7SEG_SCAN -- requirements
Module: bcd_7seg_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000, clock cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter LZB, default 1, leading-zero blanking enable; 1 = enabled, 0 = disabled.
REQ-003 Port clk  input  1  system clock; all logic is synchronous to the rising edge.
REQ-004 Port rst  input  1  synchronous active-high reset.
REQ-005 Port done  input  1  single-cycle pulse from bin2BCD marking BCD valid.
REQ-006 Port BCD  input  3x4 (logic [3:0] BCD [3])  BCD[0] units, BCD[1] tens, BCD[2] hundreds.
REQ-007 Port seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 Port an  output  4  digit anodes, active-low, registered; an[k] selects digit k.

Function
REQ-009 On a clk edge with done=1, all three BCD digits SHALL be captured into an internal register and a valid flag set; BCD SHALL be ignored when done=0.
REQ-010 Prescaler: counter 0..CLK_DIV-1, wrapping to 0; tick asserted when counter = CLK_DIV-1.
REQ-011 Digit index: 2-bit counter advancing on tick, 0->1->2->0; value 3 SHALL never occur.
REQ-012 an SHALL be one-hot-low on the index (0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011); an[3] SHALL always be 1.
REQ-013 an and seg SHALL update on the same edge, one cycle after index changes; each slot lasts exactly CLK_DIV cycles.
REQ-014 Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-015 Digit codes 10..15 SHALL display a dash (seg = 0111111).
REQ-016 Blank digit: its anode SHALL remain high for its slot and seg = 1111111.
REQ-017 With LZB=1: digit 2 blank if 0; digit 1 blank if digits 2 and 1 are both 0; digit 0 never blanked.
REQ-018 While valid=0, all slots SHALL be blank (an = 4'b1111, seg = 1111111); the scan counters SHALL keep running.
REQ-019 A done pulse mid-slot SHALL update the captured value; the new value appears at the next slot boundary, with no change to the current slot's seg.
REQ-020 Back-to-back done pulses: the last one captured wins; no pulse is lost relative to the register.

Reset
REQ-021 When rst=1: prescaler = 0, index = 0, captured digits = 0, valid = 0, an = 4'b1111, seg = 7'b1111111, effective on the next edge.
REQ-022 rst SHALL take priority over a simultaneous done; reset mid-scan returns to the blank state until the next done.

Structure
REQ-023 Package seg7_pkg SHALL hold the segment pattern constants (digits 0-9, DASH, BLANK) and the digit-count constant NUM_DIGITS = 3.
REQ-024 Sub-module seg7_decoder (combinational, 4-bit code in, 7-bit active-low pattern out) SHALL be instantiated once, on the selected digit.

Verification (CLK_DIV = 4)
REQ-025 Reset: assert rst for 2 cycles -> an = 1111, seg = 1111111; the display stays blank for 24 cycles without done.
REQ-026 Capture and scan: BCD = {2,5,5} with a done pulse -> repeating slot sequence, 4 cycles per slot:
  - an = 1110 with seg = 0010010;
  - an = 1101 with seg = 0010010;
  - an = 1011 with seg = 0100100.
REQ-027 Leading-zero blanking (LZB=1): BCD = {0,0,7} with done -> digits 2 and 1 dark, digit 0 shows seg = 1111000. With LZB=0, digits 2 and 1 show 1000000.
REQ-028 Capture hold: change BCD to {1,2,3} without done -> display unchanged. Pulse done mid-slot -> the new value appears from the next slot edge.
REQ-029 Invalid digit: BCD[1] = 4'hC -> seg = 0111111 during the index-1 slot.
REQ-030 Reset mid-scan and simultaneous events: assert rst in slot 1 -> blank on the next edge, index = 0. Assert rst together with done -> valid remains 0.
